memory_ws: RTL and testbench

- Parametrised single-port 32-bit memory model with byte-lane writes, configurable depth and separate read/write wait states.
- Presents the CPU memory handshake: the address phase is accepted when bsy=0; the data phase follows, stretched by bsy.
- Lets the platform model slow on-chip SRAM or ROM timing behind the same bus without changing masters.
- Used in simulation and FPGA builds in place of the zero-wait memory.

---
 rtl/memory_ws_if.sv | 13 +
 rtl/memory_ws.sv | 61 ++++++
 tb/tb_memory_ws.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/memory_ws_if.sv
// memory_ws_if: CPU memory handshake bundle, address phase accepted when bsy=0.
interface memory_ws_if #(parameter int AW = 18);
    logic          sel;
    logic [AW-1:0] a;
    logic [3:0]    be;
    logic [31:0]   d;
    logic          wr;
    logic          bsy;
    logic [31:0]   q;
    logic          qv;
    modport master(output sel, a, be, d, wr, input bsy, q, qv);
    modport slave(input sel, a, be, d, wr, output bsy, q, qv);
endinterface

// File: rtl/memory_ws.sv
// memory_ws: single-port 32-bit byte-lane memory with separate read/write wait states.
module memory_ws #(
    parameter int AW      = 18,
    parameter int WAIT_RD = 0,
    parameter int WAIT_WR = 0
) (
    input logic        clk,
    input logic        rst,
    memory_ws_if.slave bus
);
    localparam int DEPTH = 2 ** (AW - 2);
    typedef enum logic [1:0] {IDLE, WAIT, LAST} state_t;
    state_t        st, st_n;
    logic [3:0]    cnt, cnt_n, wsel;
    logic [AW-3:0] addr;
    logic [3:0]    be_r;
    logic [31:0]   d_r, q_r;
    logic          wr_r, acc, rd_last, wr_last;
    logic [31:0]   mem [DEPTH];
    logic          unused_ok;
    assign unused_ok = &{1'b0, bus.a[1:0]};
    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= IDLE;
            cnt <= 4'd0;
            q_r <= 32'd0;
        end else begin
            st  <= st_n;
            cnt <= cnt_n;
            if (rd_last) q_r <= mem[addr];
        end
    end
    // Wait count comes from the wr being accepted, so it follows the latched transfer.
    always_comb begin
        acc   = bus.sel && st != WAIT;
        wsel  = bus.wr ? 4'(WAIT_WR) : 4'(WAIT_RD);
        st_n  = st == WAIT ? (cnt == 4'd1 ? LAST : WAIT) : acc ? (wsel == 4'd0 ? LAST : WAIT) : IDLE;
        cnt_n = st == WAIT ? cnt - 4'd1 : acc ? wsel : 4'd0;
    end
    always_comb begin
        rd_last = st == LAST && !wr_r;
        wr_last = st == LAST && wr_r;
    end
    assign bus.bsy = st == WAIT;
    assign bus.qv  = rd_last;
    assign bus.q   = rd_last ? mem[addr] : q_r;
    always_ff @(posedge clk) begin
        if (acc) begin
            addr <= bus.a[AW-1:2];
            be_r <= bus.be;
            d_r  <= bus.d;
            wr_r <= bus.wr;
        end
    end
    // Per-lane writes so synthesis maps onto byte-enable RAM; reset aborts a pending write.
    always_ff @(posedge clk) begin
        if (wr_last && !rst)
            for (int i = 0; i < 4; i++)
                if (be_r[i]) mem[addr][8*i +: 8] <= d_r[8*i +: 8];
    end
endmodule

// File: tb/tb_memory_ws.sv
// tb_memory_ws: directed checks of memory_ws across three wait/size configurations.
module tb_memory_ws;
    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    int total = 0;
    int bad = 0;
    logic [31:0] sb [64];
    localparam int WR2 = 1;
    localparam int WW2 = 2;
    always #5 clk = ~clk;
    memory_ws_if #(.AW(18)) b0();
    memory_ws_if #(.AW(18)) b1();
    memory_ws_if #(.AW(10)) b2();
    memory_ws #(.AW(18)) u0(.clk(clk), .rst(rst0), .bus(b0));
    memory_ws #(.AW(18), .WAIT_RD(3), .WAIT_WR(1)) u1(.clk(clk), .rst(rst1), .bus(b1));
    memory_ws #(.AW(10), .WAIT_RD(WR2), .WAIT_WR(WW2)) u2(.clk(clk), .rst(rst2), .bus(b2));

    task automatic b0_req(input logic s, input logic w, input logic [17:0] addr, input logic [3:0] bev, input logic [31:0] dv);
        b0.sel = s; b0.wr = w; b0.a = addr; b0.be = bev; b0.d = dv;
        @(negedge clk);
    endtask

    task automatic b1_req(input logic s, input logic w, input logic [17:0] addr, input logic [3:0] bev, input logic [31:0] dv);
        b1.sel = s; b1.wr = w; b1.a = addr; b1.be = bev; b1.d = dv;
        @(negedge clk);
    endtask

    // Returns at the negedge inside the LAST cycle of the transfer.
    task automatic b2_xfer(input logic w, input logic [9:0] addr, input logic [3:0] bev, input logic [31:0] dv);
        b2.sel = 1'b1; b2.wr = w; b2.a = addr; b2.be = bev; b2.d = dv;
        @(negedge clk);
        b2.sel = 1'b0;
        repeat (w ? WW2 : WR2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        b0.sel = 0; b0.wr = 0; b0.a = '0; b0.be = 0; b0.d = 0;
        b1.sel = 0; b1.wr = 0; b1.a = '0; b1.be = 0; b1.d = 0;
        b2.sel = 0; b2.wr = 0; b2.a = '0; b2.be = 0; b2.d = 0;
        repeat (2) @(negedge clk);
        total++; if ({b0.bsy, b0.qv, b0.q} !== 34'd0) begin bad++; $display("FAIL reset_u0 got=%h exp=0", {b0.bsy, b0.qv, b0.q}); end
        total++; if ({b1.bsy, b1.qv, b1.q} !== 34'd0) begin bad++; $display("FAIL reset_u1 got=%h exp=0", {b1.bsy, b1.qv, b1.q}); end
        total++; if ({b2.bsy, b2.qv, b2.q} !== 34'd0) begin bad++; $display("FAIL reset_u2 got=%h exp=0", {b2.bsy, b2.qv, b2.q}); end
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    endtask

    task automatic test_zero_wait();
        b0_req(1, 1, 18'h100, 4'hF, 32'hDEADBEEF);
        total++; if (b0.bsy !== 1'b0) begin bad++; $display("FAIL zw_wr_bsy got=%b exp=0", b0.bsy); end
        b0_req(1, 0, 18'h100, 4'hF, 32'h0);
        total++; if (b0.bsy !== 1'b0) begin bad++; $display("FAIL zw_rd_bsy got=%b exp=0", b0.bsy); end
        total++; if (b0.qv !== 1'b1) begin bad++; $display("FAIL zw_qv got=%b exp=1", b0.qv); end
        total++; if (b0.q !== 32'hDEADBEEF) begin bad++; $display("FAIL zw_q got=%h exp=deadbeef", b0.q); end
        b0_req(0, 0, 18'h0, 4'h0, 32'h0);
        total++; if (b0.qv !== 1'b0) begin bad++; $display("FAIL zw_qv_idle got=%b exp=0", b0.qv); end
        total++; if (b0.q !== 32'hDEADBEEF) begin bad++; $display("FAIL zw_q_hold got=%h exp=deadbeef", b0.q); end
    endtask

    task automatic test_byte_lanes();
        b0_req(1, 1, 18'h200, 4'hF, 32'h11223344);
        b0_req(1, 1, 18'h200, 4'b0101, 32'hAABBCCDD);
        b0_req(1, 0, 18'h200, 4'hF, 32'h0);
        total++; if (b0.q !== 32'h11BB33DD) begin bad++; $display("FAIL lanes_q got=%h exp=11bb33dd", b0.q); end
        b0_req(1, 1, 18'h200, 4'h0, 32'hFFFFFFFF);
        total++; if (b0.bsy !== 1'b0) begin bad++; $display("FAIL be0_bsy got=%b exp=0", b0.bsy); end
        b0_req(1, 0, 18'h203, 4'hF, 32'h0);
        total++; if (b0.q !== 32'h11BB33DD) begin bad++; $display("FAIL be0_q got=%h exp=11bb33dd", b0.q); end
        b0_req(0, 0, 18'h0, 4'h0, 32'h0);
    endtask

    task automatic test_waits();
        b1_req(1, 1, 18'h10, 4'hF, 32'hCAFEF00D);
        total++; if (b1.bsy !== 1'b1) begin bad++; $display("FAIL wr_wait_bsy got=%b exp=1", b1.bsy); end
        b1_req(1, 1, 18'h10, 4'hF, 32'h0BADBAD0);
        total++; if ({b1.bsy, b1.qv} !== 2'b00) begin bad++; $display("FAIL wr_last got=%b exp=00", {b1.bsy, b1.qv}); end
        b1_req(1, 0, 18'h10, 4'hF, 32'h0);
        total++; if ({b1.bsy, b1.qv} !== 2'b10) begin bad++; $display("FAIL rd_w1 got=%b exp=10", {b1.bsy, b1.qv}); end
        b1_req(1, 1, 18'h10, 4'hF, 32'h0);
        total++; if ({b1.bsy, b1.qv} !== 2'b10) begin bad++; $display("FAIL rd_w2 got=%b exp=10", {b1.bsy, b1.qv}); end
        b1_req(1, 1, 18'h14, 4'hF, 32'h1);
        total++; if ({b1.bsy, b1.qv} !== 2'b10) begin bad++; $display("FAIL rd_w3 got=%b exp=10", {b1.bsy, b1.qv}); end
        b1_req(0, 0, 18'h0, 4'h0, 32'h0);
        total++; if ({b1.bsy, b1.qv} !== 2'b01) begin bad++; $display("FAIL rd_last got=%b exp=01", {b1.bsy, b1.qv}); end
        total++; if (b1.q !== 32'hCAFEF00D) begin bad++; $display("FAIL rd_q got=%h exp=cafef00d", b1.q); end
        b1_req(0, 0, 18'h0, 4'h0, 32'h0);
        total++; if ({b1.bsy, b1.qv, b1.q} !== {2'b00, 32'hCAFEF00D}) begin bad++; $display("FAIL rd_idle got=%h exp=cafef00d", {b1.bsy, b1.qv, b1.q}); end
    endtask

    task automatic test_wrap();
        b2_xfer(1, 10'h3FC, 4'hF, 32'h12345678);
        b2_xfer(0, 10'h3FC, 4'hF, 32'h0);
        total++; if ({b2.qv, b2.q} !== {1'b1, 32'h12345678}) begin bad++; $display("FAIL wrap got=%h exp=112345678", {b2.qv, b2.q}); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        b2_xfer(1, 10'h40, 4'hF, 32'h0);
        @(negedge clk);
        b2.sel = 1'b1; b2.wr = 1'b1; b2.a = 10'h40; b2.be = 4'hF; b2.d = 32'h5;
        @(negedge clk);
        total++; if (b2.bsy !== 1'b1) begin bad++; $display("FAIL rmw_bsy got=%b exp=1", b2.bsy); end
        b2.sel = 1'b0; rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        total++; if ({b2.bsy, b2.qv, b2.q} !== 34'd0) begin bad++; $display("FAIL rmw_reset got=%h exp=0", {b2.bsy, b2.qv, b2.q}); end
        b2_xfer(0, 10'h40, 4'hF, 32'h0);
        total++; if ({b2.qv, b2.q} !== {1'b1, 32'h0}) begin bad++; $display("FAIL rmw_read got=%h exp=100000000", {b2.qv, b2.q}); end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 32; i < 48; i++) begin
            sb[i] = $urandom;
            b2_xfer(1, 10'(i * 4), 4'hF, sb[i]);
        end
        for (int n = 0; n < 1000; n++) begin
            logic w;
            int idx;
            logic [3:0] bev;
            logic [31:0] dv;
            w = 1'($urandom_range(0, 1));
            idx = 32 + int'($urandom_range(0, 15));
            bev = 4'($urandom);
            dv = $urandom;
            b2_xfer(w, 10'(idx * 4 + int'($urandom_range(0, 3))), bev, dv);
            if (!w) begin
                total++;
                if ({b2.qv, b2.q} !== {1'b1, sb[idx]}) begin bad++; $display("FAIL rand_%0d got=%h exp=1%h", n, {b2.qv, b2.q}, sb[idx]); end
            end else begin
                for (int k = 0; k < 4; k++)
                    if (bev[k]) sb[idx][8*k +: 8] = dv[8*k +: 8];
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) b0_req(1, 1, 18'(i * 4), 4'hF, 32'hA5000000 + 32'(i));
        for (int i = 0; i < 8; i++) begin
            b0_req(1, 0, 18'(i * 4), 4'hF, 32'h0);
            total++;
            if ({b0.bsy, b0.qv, b0.q} !== {2'b01, 32'hA5000000 + 32'(i)}) begin bad++; $display("FAIL b2b_%0d got=%h exp=%h", i, {b0.bsy, b0.qv, b0.q}, {2'b01, 32'hA5000000 + 32'(i)}); end
        end
        b0_req(0, 0, 18'h0, 4'h0, 32'h0);
        total++; if (b0.qv !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", b0.qv); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_byte_lanes();
        test_waits();
        test_wrap();
        test_reset_mid_write();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
